// File: rtl/param_mac_accumulator_if.sv
// Handshake bundle between the multiplier stream, the accumulator and the
// result consumer. Widths follow the accumulator parameters.
interface param_mac_accumulator_if #(
  parameter int WIDTH = 8,
  parameter int GUARD = 8,
  parameter int CNT_W = 16
);
  localparam int ACC_W = 2*WIDTH + GUARD;

  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] product;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   acc_out;
  logic [CNT_W-1:0]   out_count;
  logic               overflow;

  // Environment side: produces beats, consumes results.
  modport master (
    output in_valid, product, in_last, out_ready,
    input  in_ready, out_valid, acc_out, out_count, overflow
  );

  // Accumulator side.
  modport slave (
    input  in_valid, product, in_last, out_ready,
    output in_ready, out_valid, acc_out, out_count, overflow
  );
endinterface

// File: rtl/param_mac_accumulator.sv
// Saturating unsigned accumulator for dot-product frames. Sums product beats
// until a beat tagged in_last, then holds the result (sum, beat count,
// overflow flag) until downstream takes it, and starts a fresh frame.
module param_mac_accumulator #(
  parameter int WIDTH = 8,
  parameter int GUARD = 8,
  parameter int CNT_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  param_mac_accumulator_if.slave bus
);
  localparam int ACC_W = 2*WIDTH + GUARD;
  localparam int SUM_W = ACC_W + 1;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [SUM_W-1:0] sum;
  logic             accept;
  logic             out_fire;

  // Handshakes qualified by state only; ready/valid are pure state decodes.
  always_comb begin
    accept   = bus.in_valid  && (state_q == ACCUM);
    out_fire = bus.out_ready && (state_q == HOLD);
  end

  // One extra bit of sum exposes a carry out of the accumulator for saturation.
  always_comb begin
    sum = {1'b0, acc_q} + SUM_W'(bus.product);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // Next state: last beat enters HOLD, result acceptance returns to ACCUM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: if (accept && bus.in_last) state_d = HOLD;
      HOLD:  if (out_fire)              state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Accumulator, beat counter and sticky overflow; all clear on result handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      if (sum[ACC_W]) begin
        acc_q <= '1;
        ovf_q <= 1'b1;
      end else begin
        acc_q <= sum[ACC_W-1:0];
      end
      if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end else if (out_fire) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end
  end

  // Output decode.
  always_comb begin
    bus.in_ready  = (state_q == ACCUM);
    bus.out_valid = (state_q == HOLD);
    bus.acc_out   = acc_q;
    bus.out_count = cnt_q;
    bus.overflow  = ovf_q;
  end
endmodule

// File: tb/tb_param_mac_accumulator.sv
// Directed bench for param_mac_accumulator (WIDTH=8, GUARD=8, CNT_W=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_param_mac_accumulator;
  localparam int WIDTH = 8;
  localparam int GUARD = 8;
  localparam int CNT_W = 16;

  logic clk;
  logic rst;
  int unsigned total;
  int unsigned bad;

  param_mac_accumulator_if #(.WIDTH(WIDTH), .GUARD(GUARD), .CNT_W(CNT_W)) bus ();

  param_mac_accumulator #(.WIDTH(WIDTH), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [63:0] acc,
                         input logic [63:0] cnt, input logic of);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ov));
    chk({tag, ".acc_out"},   64'(bus.acc_out),   acc);
    chk({tag, ".out_count"}, 64'(bus.out_count), cnt);
    chk({tag, ".overflow"},  64'(bus.overflow),  64'(of));
  endtask

  // Offer a beat at the current falling edge, hold it until accepted, and
  // return at the falling edge after the accepting rising edge. in_valid is
  // left high; the caller drops it or offers the next beat.
  task automatic beat(input logic [2*WIDTH-1:0] p, input logic last);
    int unsigned waited;
    bus.in_valid = 1'b1;
    bus.product  = p;
    bus.in_last  = last;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
      if (bus.product !== p || bus.in_valid !== 1'b1) chk("beat_stable", 64'(bus.product), 64'(p));
    end
    if (!bus.in_ready) chk("beat_timeout.in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.product  = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.product   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk_out("reset", 1'b0, 0, 0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.in_ready", 64'(bus.in_ready), 64'd1);

    // Basic frame 10,20,30
    bus.out_ready = 1'b1;
    beat(16'd10, 1'b0);
    chk("basic.running_acc", 64'(bus.acc_out), 64'd10);
    beat(16'd20, 1'b0);
    beat(16'd30, 1'b1);
    idle();
    chk_out("basic", 1'b1, 60, 3, 1'b0);
    chk("basic.in_ready_hold", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    chk("basic.in_ready_after", 64'(bus.in_ready), 64'd1);
    chk_out("basic.cleared", 1'b0, 0, 0, 1'b0);

    // 258 beats of 65025: just below saturation
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 258; i++) beat(16'd65025, (i == 258));
    idle();
    chk_out("sat258", 1'b1, 16776450, 258, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // 259 beats of 65025: saturates
    for (int i = 1; i <= 259; i++) beat(16'd65025, (i == 259));
    idle();
    chk_out("sat259", 1'b1, 16777215, 259, 1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_out("sat.cleared", 1'b0, 0, 0, 1'b0);

    // Backpressure: {5, 7 last}, result held 5 cycles while 99 is offered
    bus.out_ready = 1'b0;
    beat(16'd5, 1'b0);
    beat(16'd7, 1'b1);
    bus.in_valid = 1'b1;
    bus.product  = 16'd99;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_out("bp.hold", 1'b1, 12, 2, 1'b0);
      chk("bp.in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_out("bp.released", 1'b0, 0, 0, 1'b0);
    chk("bp.in_ready_after", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    chk_out("bp.first_beat_99", 1'b0, 99, 1, 1'b0);
    beat(16'd1, 1'b1);
    idle();
    chk_out("bp.frame2", 1'b1, 100, 2, 1'b0);
    @(negedge clk);

    // Single-beat frame with zero product
    beat(16'd0, 1'b1);
    idle();
    chk_out("single_zero", 1'b1, 0, 1, 1'b0);
    @(negedge clk);

    // Reset mid-frame, not aligned to an edge; released just before an edge
    bus.out_ready = 1'b0;
    beat(16'd100, 1'b0);
    beat(16'd200, 1'b0);
    idle();
    chk_out("midrst.before", 1'b0, 300, 2, 1'b0);
    #2 rst = 1'b1;
    #1 chk_out("midrst.during", 1'b0, 0, 0, 1'b0);
    bus.in_valid = 1'b1;
    bus.product  = 16'd3;
    bus.in_last  = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    idle();
    chk_out("midrst.next", 1'b1, 3, 1, 1'b0);

    // Reset while a result is pending in HOLD
    #2 rst = 1'b1;
    #1 chk_out("holdrst", 1'b0, 0, 0, 1'b0);
    chk("holdrst.in_ready", 64'(bus.in_ready), 64'd1);
    #1 rst = 1'b0;
    @(negedge clk);

    // Back-to-back with in_valid and out_ready held high: {1, 2 last, 4 last}
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.product   = 16'd1;
    bus.in_last   = 1'b0;
    @(negedge clk);
    bus.product = 16'd2;
    bus.in_last = 1'b1;
    @(negedge clk);
    chk_out("b2b.frame1", 1'b1, 3, 2, 1'b0);
    bus.product = 16'd4;
    bus.in_last = 1'b1;
    @(negedge clk);
    chk_out("b2b.between", 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    chk_out("b2b.frame2", 1'b1, 4, 1, 1'b0);
    idle();
    @(negedge clk);
    chk("b2b.in_ready_end", 64'(bus.in_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/param_mac_accumulator.md
PARAM_MAC_ACCUMULATOR -- requirements
Module: param_mac_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width of the upstream param_multiplier; the product input is 2*WIDTH bits.
REQ-002 SHALL have parameter GUARD, default 8: guard bits; ACC_W = 2*WIDTH+GUARD.
REQ-003 SHALL have parameter CNT_W, default 16: beat-counter width.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, as listed in REQ-005 and REQ-006.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  product beat valid.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 product  input  2*WIDTH  unsigned product from param_multiplier.
REQ-010 in_last  input  1  marks the final beat of a dot-product; sampled with the beat.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 acc_out  output  ACC_W  accumulated unsigned sum.
REQ-014 out_count  output  CNT_W  number of beats accepted in the completed frame.
REQ-015 overflow  output  1  sticky flag: the frame saturated.

Function
REQ-016 SHALL implement a two-state FSM: ACCUM and HOLD.
REQ-017 in_ready SHALL equal 1 exactly when the state is ACCUM; it is decoded from the state register only, with no combinational path from in_valid or out_ready.
REQ-018 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-019 On each accepted beat, the accumulator SHALL become acc + zero-extended product.
REQ-020 If that sum exceeds 2^ACC_W-1, the accumulator SHALL take 2^ACC_W-1 and overflow SHALL be set to 1.
REQ-021 Once saturated, the accumulator SHALL stay at 2^ACC_W-1 for the rest of the frame.
REQ-022 On each accepted beat, the counter SHALL increment by 1 and saturate at 2^CNT_W-1; it SHALL never wrap.
REQ-023 An accepted beat with in_last=1 SHALL be included in the sum and the count, and SHALL move the FSM to HOLD on the same edge.
REQ-024 out_valid SHALL be 1 in the cycle after that edge (latency 1 from the last-beat acceptance edge).
REQ-025 out_valid SHALL equal 1 exactly when the state is HOLD.
REQ-026 In HOLD, acc_out, out_count and overflow SHALL hold stable until the result is accepted (out_valid and out_ready both 1 at an edge).
REQ-027 On that acceptance edge, the accumulator, counter and overflow SHALL clear to 0 and the FSM SHALL return to ACCUM; in_ready is 1 in the next cycle.
REQ-028 In ACCUM, acc_out and out_count SHALL show the running value (informational only).
REQ-029 in_valid arriving while in HOLD SHALL be ignored: no state change, and the upstream holds the beat per the valid/ready rule.
REQ-030 out_ready SHALL be ignored while in ACCUM.
REQ-031 Only one handshake can fire per cycle, because in_ready and out_valid are never both 1.
REQ-032 A beat with product=0 SHALL still increment the count.
REQ-033 All arithmetic SHALL be unsigned.
REQ-034 Once in_valid is raised, the upstream SHALL keep it high and keep product and in_last stable until accepted; the bench checks this.

Reset
REQ-035 rst=1 SHALL asynchronously force: state=ACCUM, accumulator=0, counter=0, overflow=0, out_valid=0.
REQ-036 After reset is released, in_ready SHALL be 1.
REQ-037 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending result with no output handshake.
REQ-038 The first edge after rst is deasserted SHALL be able to accept a beat.

Verification (WIDTH=8, GUARD=8, ACC_W=24, CNT_W=16)
REQ-039 Basic frame: products 10, 20, 30 (last on the third beat), out_ready=1 -> out_valid=1 one cycle after the third acceptance; acc_out=60, out_count=3, overflow=0; in_ready=1 on the following cycle.
REQ-040 Saturation: 259 beats of product=65025, last on beat 259 -> acc_out=16777215, overflow=1, out_count=259; with 258 beats -> acc_out=16776450, overflow=0.
REQ-041 Backpressure: frame {5, 7 last} with out_ready=0 for 5 cycles -> out_valid stays 1, acc_out stays 12, in_ready stays 0, and an offered in_valid=1 beat (product 99) is not consumed; after out_ready=1, the next frame accepts 99 as its first beat.
REQ-042 Single-beat frame: product=0 with in_last=1 -> acc_out=0, out_count=1, overflow=0.
REQ-043 Reset mid-frame: products 100, 200 accepted, then rst pulsed asynchronously (not edge-aligned) -> out_valid=0, acc_out=0, out_count=0 immediately; next frame {3 last} -> acc_out=3, out_count=1.
REQ-044 Back-to-back frames: out_ready held at 1 and in_valid held at 1, stream {1, 2 last, 4 last} -> results 3 (count 2) and then 4 (count 1), with overflow cleared between frames.
